// File: rtl/conv3x3_engine_if.sv
// Handshake and memory-port bundle between the controller/memory side and one
// conv3x3_engine channel; the engine uses the slave modport.
interface conv3x3_engine_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              done;
    logic [ADDR_W-1:0] krn_addr;
    logic signed [7:0] krn_data;
    logic [ADDR_W-1:0] img_addr;
    logic [7:0]        img_data;
    logic [ADDR_W-1:0] out_addr;
    logic [7:0]        out_data;
    logic              out_we;

    modport slave (
        input  start, krn_data, img_data,
        output done, krn_addr, img_addr, out_addr, out_data, out_we
    );

    modport master (
        output start, krn_data, img_data,
        input  done, krn_addr, img_addr, out_addr, out_data, out_we
    );
endinterface

// File: rtl/conv3x3_engine.sv
// 3x3 valid-padding convolution channel: loads a kernel, convolves the image tap by tap
// and writes clamped 8-bit results row-major. Define CONV_BIAS_EN to add a per-kernel bias.
module conv3x3_engine #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 16,
    parameter int SHIFT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    conv3x3_engine_if.slave  bus
);
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 21;
    localparam int PROD_W = DATA_W + COEF_W + 1;
`ifdef CONV_BIAS_EN
    localparam logic [3:0] LK_LAST = 4'd10;
`else
    localparam logic [3:0] LK_LAST = 4'd9;
`endif
    localparam logic [3:0]              PIX_LAST = 4'd9;
    localparam logic [ADDR_W-1:0]       ROW_STEP = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0]       C_LAST   = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0]       R_LAST   = ADDR_W'(IMG_H - 3);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(255);

    typedef enum logic [2:0] {S_IDLE, S_LOADK, S_PIX, S_WR, S_DONE} state_t;

    state_t                    r_state, w_next;
    logic [3:0]                r_cnt;
    logic signed [COEF_W-1:0]  r_kern [0:8];
    logic signed [ACC_W-1:0]   r_acc;
    logic [1:0]                r_tj;
    logic [ADDR_W-1:0]         r_row, r_col, r_base, r_oaddr;
    logic                      r_done, r_we;
    logic [ADDR_W-1:0]         r_krn_addr, r_img_addr, r_out_addr;
    logic [DATA_W-1:0]         r_out_data;

    logic signed [COEF_W-1:0]  w_coef;
    logic signed [DATA_W:0]    w_pix;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_mac, w_acc_init;
    logic                      w_last_px;

    function automatic logic [DATA_W-1:0] sat_u8(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s[ACC_W-1])    return '0;
        if (s > SAT_MAX)   return '1;
        return s[DATA_W-1:0];
    endfunction

`ifdef CONV_BIAS_EN
    logic signed [COEF_W-1:0] r_bias;
    // Bias is pre-scaled so it lands in the same fixed-point position as the products.
    assign w_acc_init = ACC_W'(r_bias) <<< SHIFT;
`else
    assign w_acc_init = '0;
`endif

    always_comb begin
        w_coef = '0;
        if (r_cnt != 4'd0 && r_cnt <= 4'd9) w_coef = r_kern[r_cnt - 4'd1];
    end

    assign w_pix     = $signed({1'b0, bus.img_data});
    assign w_prod    = PROD_W'(w_pix) * PROD_W'(w_coef);
    assign w_mac     = r_acc + ACC_W'(w_prod);
    assign w_last_px = (r_row == R_LAST) && (r_col == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)           w_next = S_LOADK;
            S_LOADK: if (r_cnt == LK_LAST)    w_next = S_PIX;
            S_PIX:   if (r_cnt == PIX_LAST)   w_next = S_WR;
            S_WR:    w_next = w_last_px ? S_DONE : S_PIX;
            S_DONE:  if (!bus.start)          w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_tj       <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_base     <= '0;
            r_oaddr    <= '0;
            r_done     <= 1'b0;
            r_we       <= 1'b0;
            r_krn_addr <= '0;
            r_img_addr <= '0;
            r_out_addr <= '0;
            r_out_data <= '0;
            for (int k = 0; k < 9; k++) r_kern[k] <= '0;
`ifdef CONV_BIAS_EN
            r_bias     <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.start) r_krn_addr <= '0;
                end
                // Kernel load: address leads the captured tap by one cycle.
                S_LOADK: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt < LK_LAST - 4'd1) r_krn_addr <= r_krn_addr + ADDR_W'(1);
                    if (r_cnt != 4'd0 && r_cnt <= 4'd9) r_kern[r_cnt - 4'd1] <= bus.krn_data;
`ifdef CONV_BIAS_EN
                    if (r_cnt == 4'd10) r_bias <= bus.krn_data;
`endif
                    if (r_cnt == LK_LAST) begin
                        r_cnt      <= '0;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_base     <= '0;
                        r_oaddr    <= '0;
                        r_tj       <= '0;
                        r_img_addr <= '0;
                    end
                end
                // Per-pixel fetch/MAC: tap k is fetched in cycle k and accumulated in k+1.
                S_PIX: begin
                    r_cnt <= r_cnt + 4'd1;
                    r_acc <= (r_cnt == 4'd0) ? w_acc_init : w_mac;
                    if (r_cnt < 4'd8) begin
                        if (r_tj == 2'd2) begin
                            r_tj       <= '0;
                            r_img_addr <= r_img_addr + ROW_STEP;
                        end else begin
                            r_tj       <= r_tj + 2'd1;
                            r_img_addr <= r_img_addr + ADDR_W'(1);
                        end
                    end
                    if (r_cnt == PIX_LAST) begin
                        r_cnt      <= '0;
                        r_we       <= 1'b1;
                        r_out_data <= sat_u8(w_mac);
                        r_out_addr <= r_oaddr;
                    end
                end
                // Write cycle: advance to the next window origin.
                S_WR: begin
                    r_oaddr <= r_oaddr + ADDR_W'(1);
                    r_tj    <= '0;
                    if (r_col == C_LAST) begin
                        r_col      <= '0;
                        r_row      <= r_row + ADDR_W'(1);
                        r_base     <= r_base + ADDR_W'(3);
                        r_img_addr <= r_base + ADDR_W'(3);
                    end else begin
                        r_col      <= r_col + ADDR_W'(1);
                        r_base     <= r_base + ADDR_W'(1);
                        r_img_addr <= r_base + ADDR_W'(1);
                    end
                    if (w_last_px) r_done <= 1'b1;
                end
                S_DONE: begin
                    if (!bus.start) r_done <= 1'b0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.done     = r_done;
    assign bus.out_we   = r_we;
    assign bus.krn_addr = r_krn_addr;
    assign bus.img_addr = r_img_addr;
    assign bus.out_addr = r_out_addr;
    assign bus.out_data = r_out_data;
endmodule

// File: tb/tb_conv3x3_engine.sv
// Bench for conv3x3_engine: two channels (4x4 SHIFT=0, 6x5 SHIFT=2) sharing kernel and
// image memories, checked against a plain-arithmetic convolution model.
module tb_conv3x3_engine;
    localparam int AW = 4, AH = 4, BW = 6, BH = 5;
`ifdef CONV_BIAS_EN
    localparam int BX = 1;
`else
    localparam int BX = 0;
`endif
    localparam int LAT_A = 1 + 10 + 11 * (AW - 2) * (AH - 2) + BX;
    localparam int LAT_B = 1 + 10 + 11 * (BW - 2) * (BH - 2) + BX;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv3x3_engine_if #(.ADDR_W(16)) ifa ();
    conv3x3_engine_if #(.ADDR_W(16)) ifb ();

    conv3x3_engine #(.IMG_W(AW), .IMG_H(AH), .ADDR_W(16), .SHIFT(0)) u_a (
        .clk(clk), .reset(reset), .bus(ifa));
    conv3x3_engine #(.IMG_W(BW), .IMG_H(BH), .ADDR_W(16), .SHIFT(2)) u_b (
        .clk(clk), .reset(reset), .bus(ifb));

    logic [7:0] kmem [0:15];
    logic [7:0] imem [0:255];

    // Synchronous-read memories: data one cycle after address.
    always @(posedge clk) begin
        ifa.krn_data <= kmem[ifa.krn_addr[3:0]];
        ifa.img_data <= imem[ifa.img_addr[7:0]];
        ifb.krn_data <= kmem[ifb.krn_addr[3:0]];
        ifb.img_data <= imem[ifb.img_addr[7:0]];
    end

    int wa_a[$], wa_d[$], wb_a[$], wb_d[$], ex_a[$], ex_d[$];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (ifa.out_we === 1'b1) begin
            wa_a.push_back(int'(ifa.out_addr));
            wa_d.push_back(int'(ifa.out_data));
        end
        if (ifb.out_we === 1'b1) begin
            wb_a.push_back(int'(ifb.out_addr));
            wb_d.push_back(int'(ifb.out_data));
        end
    end

    // Reference: direct convolution over the memories, floor shift, clamp to 0..255.
    task automatic build_expected(input int w, input int h, input int sh);
        int acc, res;
        ex_a.delete();
        ex_d.delete();
        for (int r = 0; r < h - 2; r++)
            for (int c = 0; c < w - 2; c++) begin
`ifdef CONV_BIAS_EN
                acc = int'($signed(kmem[9])) * (1 << sh);
`else
                acc = 0;
`endif
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += int'(imem[(r + i) * w + c + j]) * int'($signed(kmem[3 * i + j]));
                res = acc >>> sh;
                if (res < 0) res = 0;
                if (res > 255) res = 255;
                ex_a.push_back(r * (w - 2) + c);
                ex_d.push_back(res);
            end
    endtask

    task automatic fill_const(input logic [7:0] kv, input logic [7:0] pv);
        for (int k = 0; k < 9; k++) kmem[k] = kv;
        kmem[9] = 8'h00;
        for (int i = 0; i < 256; i++) imem[i] = pv;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 10; k++) kmem[k] = 8'($urandom);
        for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
    endtask

    task automatic start_and_wait(input int sel, output int lat);
        lat = -1;
        @(negedge clk);
        if (sel == 0) begin wa_a.delete(); wa_d.delete(); ifa.start = 1'b1; end
        else          begin wb_a.delete(); wb_d.delete(); ifb.start = 1'b1; end
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            if (((sel == 0) ? ifa.done : ifb.done) === 1'b1) begin lat = n; break; end
        end
    endtask

    task automatic stop_run(input int sel);
        @(negedge clk);
        if (sel == 0) ifa.start = 1'b0; else ifb.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({ifa.done, ifa.out_we} !== 2'b00) begin errors++; $display("FAIL reset_a_flags got %b want 00", {ifa.done, ifa.out_we}); end
        checks++; if (ifa.krn_addr !== 16'd0 || ifa.img_addr !== 16'd0) begin errors++; $display("FAIL reset_a_rdaddr got %0d/%0d want 0/0", ifa.krn_addr, ifa.img_addr); end
        checks++; if (ifa.out_addr !== 16'd0 || ifa.out_data !== 8'd0) begin errors++; $display("FAIL reset_a_out got %0d/%0d want 0/0", ifa.out_addr, ifa.out_data); end
        checks++; if ({ifb.done, ifb.out_we} !== 2'b00) begin errors++; $display("FAIL reset_b_flags got %b want 00", {ifb.done, ifb.out_we}); end
        checks++; if (ifb.krn_addr !== 16'd0 || ifb.img_addr !== 16'd0 || ifb.out_addr !== 16'd0) begin errors++; $display("FAIL reset_b_addr got %0d/%0d/%0d want 0", ifb.krn_addr, ifb.img_addr, ifb.out_addr); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ifa.done !== 1'b0 || wa_d.size() != 0) begin errors++; $display("FAIL idle_no_start got done=%b writes=%0d want 0/0", ifa.done, wa_d.size()); end
    endtask

    task automatic test_identity();
        int lat;
        int id_exp[4];
`ifdef CONV_BIAS_EN
        id_exp = '{2, 3, 6, 7};
`else
        id_exp = '{5, 6, 9, 10};
`endif
        fill_const(8'h00, 8'h00);
        kmem[4] = 8'h01;
        kmem[9] = 8'hFD;
        for (int i = 0; i < 16; i++) imem[i] = 8'(i);
        start_and_wait(0, lat);
        checks++; if (lat != LAT_A) begin errors++; $display("FAIL identity_latency got %0d want %0d", lat, LAT_A); end
        checks++; if (wa_d.size() != 4) begin errors++; $display("FAIL identity_count got %0d want 4", wa_d.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wa_d.size() || wa_a[i] != i || wa_d[i] != id_exp[i]) begin
                errors++;
                $display("FAIL identity_write%0d got %0d@%0d want %0d@%0d", i,
                         (i < wa_d.size()) ? wa_d[i] : -1, (i < wa_a.size()) ? wa_a[i] : -1, id_exp[i], i);
            end
        end
        stop_run(0);
    endtask

    task automatic test_saturation();
        int lat;
        fill_const(8'h01, 8'hFF);
        start_and_wait(0, lat);
        checks++; if (wa_d.size() != 4) begin errors++; $display("FAIL sat_count got %0d want 4", wa_d.size()); end
        for (int i = 0; i < wa_d.size(); i++) begin
            checks++; if (wa_d[i] != 255 || wa_a[i] != i) begin errors++; $display("FAIL sat_write%0d got %0d@%0d want 255@%0d", i, wa_d[i], wa_a[i], i); end
        end
        stop_run(0);
        fill_const(8'hFF, 8'd10);
        start_and_wait(0, lat);
        checks++; if (wa_d.size() != 4) begin errors++; $display("FAIL neg_count got %0d want 4", wa_d.size()); end
        for (int i = 0; i < wa_d.size(); i++) begin
            checks++; if (wa_d[i] != 0) begin errors++; $display("FAIL neg_write%0d got %0d want 0", i, wa_d[i]); end
        end
        stop_run(0);
    endtask

    task automatic test_shift();
        int lat;
        fill_const(8'h01, 8'd4);
        start_and_wait(1, lat);
        checks++; if (lat != LAT_B) begin errors++; $display("FAIL shift_latency got %0d want %0d", lat, LAT_B); end
        checks++; if (wb_d.size() != 12) begin errors++; $display("FAIL shift_count got %0d want 12", wb_d.size()); end
        for (int i = 0; i < wb_d.size(); i++) begin
            checks++; if (wb_d[i] != 9 || wb_a[i] != i) begin errors++; $display("FAIL shift_write%0d got %0d@%0d want 9@%0d", i, wb_d[i], wb_a[i], i); end
        end
        stop_run(1);
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 5; t++) begin
            int sel;
            sel = (t < 3) ? 0 : 1;
            fill_random();
            if (sel == 0) build_expected(AW, AH, 0); else build_expected(BW, BH, 2);
            start_and_wait(sel, lat);
            checks++; if (lat != ((sel == 0) ? LAT_A : LAT_B)) begin errors++; $display("FAIL rand%0d_latency got %0d", t, lat); end
            for (int i = 0; i < ex_d.size(); i++) begin
                int ga, gd;
                ga = -1; gd = -1;
                if (sel == 0 && i < wa_d.size()) begin ga = wa_a[i]; gd = wa_d[i]; end
                if (sel == 1 && i < wb_d.size()) begin ga = wb_a[i]; gd = wb_d[i]; end
                checks++;
                if (ga != ex_a[i] || gd != ex_d[i]) begin errors++; $display("FAIL rand%0d_write%0d got %0d@%0d want %0d@%0d", t, i, gd, ga, ex_d[i], ex_a[i]); end
            end
            checks++; if (((sel == 0) ? wa_d.size() : wb_d.size()) != ex_d.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", t, (sel == 0) ? wa_d.size() : wb_d.size(), ex_d.size()); end
            stop_run(sel);
        end
    endtask

    task automatic test_handshake();
        int lat;
        int first_d[$];
        logic [15:0] ka, ia;
        fill_random();
        build_expected(AW, AH, 0);
        start_and_wait(0, lat);
        ka = ifa.krn_addr;
        ia = ifa.img_addr;
        first_d = wa_d;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL hold_done got %b want 1", ifa.done); end
        checks++; if (ifa.krn_addr !== ka || ifa.img_addr !== ia || wa_d.size() != 4) begin
            errors++; $display("FAIL hold_quiet got k%0d i%0d w%0d want k%0d i%0d w4", ifa.krn_addr, ifa.img_addr, wa_d.size(), ka, ia); end
        stop_run(0);
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL drop_done got %b want 0", ifa.done); end
        start_and_wait(0, lat);
        checks++; if (lat != LAT_A || wa_d.size() != 4) begin errors++; $display("FAIL rerun got lat %0d writes %0d want %0d/4", lat, wa_d.size(), LAT_A); end
        for (int i = 0; i < wa_d.size() && i < 4; i++) begin
            checks++; if (wa_d[i] != first_d[i] || wa_d[i] != ex_d[i]) begin errors++; $display("FAIL rerun_write%0d got %0d want %0d", i, wa_d[i], ex_d[i]); end
        end
        stop_run(0);
    endtask

    task automatic test_early_drop();
        int lat;
        fill_random();
        build_expected(AW, AH, 0);
        lat = -1;
        @(negedge clk);
        wa_a.delete(); wa_d.delete();
        ifa.start = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) ifa.start = 1'b0;
            if (ifa.done === 1'b1) begin lat = n; break; end
        end
        checks++; if (lat != LAT_A) begin errors++; $display("FAIL early_latency got %0d want %0d", lat, LAT_A); end
        @(posedge clk);
        #1;
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL early_pulse got %b want 0", ifa.done); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (wa_d.size() != 4 || ifa.done !== 1'b0) begin errors++; $display("FAIL early_norerun got writes %0d done %b want 4/0", wa_d.size(), ifa.done); end
        for (int i = 0; i < wa_d.size() && i < 4; i++) begin
            checks++; if (wa_d[i] != ex_d[i]) begin errors++; $display("FAIL early_write%0d got %0d want %0d", i, wa_d[i], ex_d[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        fill_random();
        @(negedge clk);
        wa_a.delete(); wa_d.delete();
        ifa.start = 1'b1;
        repeat (42) @(posedge clk);
        #1;
        reset = 1'b1;
        ifa.start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({ifa.done, ifa.out_we} !== 2'b00) begin errors++; $display("FAIL midrst_flags got %b want 00", {ifa.done, ifa.out_we}); end
        checks++; if (ifa.krn_addr !== 16'd0 || ifa.img_addr !== 16'd0 || ifa.out_addr !== 16'd0 || ifa.out_data !== 8'd0) begin
            errors++; $display("FAIL midrst_outs got %0d/%0d/%0d/%0d want 0", ifa.krn_addr, ifa.img_addr, ifa.out_addr, ifa.out_data); end
        checks++; if (wa_d.size() != 2) begin errors++; $display("FAIL midrst_partial got %0d want 2", wa_d.size()); end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (wa_d.size() != 2 || ifa.done !== 1'b0) begin errors++; $display("FAIL midrst_quiet got writes %0d done %b want 2/0", wa_d.size(), ifa.done); end
        fill_random();
        build_expected(AW, AH, 0);
        start_and_wait(0, lat);
        checks++; if (lat != LAT_A || wa_d.size() != 4) begin errors++; $display("FAIL midrst_rerun got lat %0d writes %0d want %0d/4", lat, wa_d.size(), LAT_A); end
        for (int i = 0; i < wa_d.size() && i < 4; i++) begin
            checks++; if (wa_a[i] != ex_a[i] || wa_d[i] != ex_d[i]) begin errors++; $display("FAIL midrst_write%0d got %0d@%0d want %0d@%0d", i, wa_d[i], wa_a[i], ex_d[i], ex_a[i]); end
        end
        stop_run(0);
    endtask

    initial begin
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        fill_const(8'h00, 8'h00);
        test_reset();
        test_identity();
        test_saturation();
        test_shift();
        test_random();
        test_handshake();
        test_early_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
